// File: rtl/trace_chk_pkg.sv
// Shared definitions for the trace line checker: FSM states, ASCII tokens,
// output encodings and error-bit positions.
package trace_chk_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TIME,
        S_PC,
        S_COLON,
        S_SP_SEL,
        S_SP_FIELD,
        S_GRF,
        S_ADDR,
        S_SP_LT,
        S_EQ,
        S_SP_DATA,
        S_DATA,
        S_HASH,
        S_ACCEPT
    } state_t;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_LC_A   = 8'h61;
    localparam logic [7:0] CH_LC_F   = 8'h66;

    localparam logic [1:0] FT_NONE = 2'd0;
    localparam logic [1:0] FT_REG  = 2'd1;
    localparam logic [1:0] FT_MEM  = 2'd2;

    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_GRF  = 3;

endpackage

// File: rtl/trace_char_class.sv
// Combinational classification of one ASCII character into decimal/hex
// membership and its numeric value.
module trace_char_class
    import trace_chk_pkg::*;
(
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble,
    output logic [3:0] dec_val
);

    logic is_lc_hex;

    always_comb begin
        is_dec    = (char >= CH_0) && (char <= CH_9);
        is_lc_hex = (char >= CH_LC_A) && (char <= CH_LC_F);
        is_hex    = is_dec || is_lc_hex;
        dec_val   = is_dec ? char[3:0] : 4'd0;
        // 'a'..'f' have low nibbles 1..6, so +9 maps them onto 10..15
        nibble    = is_dec ? char[3:0] : (is_lc_hex ? char[3:0] + 4'd9 : 4'd0);
    end

endmodule

// File: rtl/trace_line_checker.sv
// Character-serial checker for CPU register/memory write trace lines.
// Define TRACE_CHECKER_ERR_EN to build the semantic checks; otherwise error_code is 0.
module trace_line_checker
    import trace_chk_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4fff,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
    parameter int          FREQ_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char,
    input  logic [FREQ_W-1:0] freq,
    output logic [1:0]        format_type,
    output logic [3:0]        error_code
);

    logic       is_dec, is_hex;
    logic [3:0] nibble, dec_val;

    trace_char_class u_class (
        .char    (char),
        .is_dec  (is_dec),
        .is_hex  (is_hex),
        .nibble  (nibble),
        .dec_val (dec_val)
    );

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       kind, kind_d;
    logic       clr, shift_time, shift_pc, shift_grf, shift_addr, accept_d;
    logic [3:0] err_d;
    logic [1:0] format_type_p1;
    logic [3:0] error_code_p1;

    always_comb begin
        state_d    = S_IDLE;
        cnt_d      = cnt;
        kind_d     = kind;
        clr        = 1'b0;
        shift_time = 1'b0;
        shift_pc   = 1'b0;
        shift_grf  = 1'b0;
        shift_addr = 1'b0;
        accept_d   = 1'b0;
        if (char == CH_CARET) begin
            state_d = S_TIME;
            cnt_d   = '0;
            clr     = 1'b1;
        end else begin
            case (state)
                S_TIME: begin
                    if (is_dec && (cnt < 8'(TIME_DIGITS))) begin
                        state_d = S_TIME; cnt_d = cnt + 8'd1; shift_time = 1'b1;
                    end else if ((char == CH_AT) && (cnt != 8'd0)) begin
                        state_d = S_PC; cnt_d = '0;
                    end
                end
                S_PC: begin
                    if (is_hex) begin
                        shift_pc = 1'b1;
                        state_d  = (cnt == 8'd7) ? S_COLON : S_PC;
                        cnt_d    = (cnt == 8'd7) ? 8'd0 : cnt + 8'd1;
                    end
                end
                S_COLON:
                    if (char == CH_COLON) state_d = S_SP_SEL;
                S_SP_SEL: begin
                    if (char == CH_SPACE) state_d = S_SP_SEL;
                    else if (char == CH_DOLLAR) begin state_d = S_SP_FIELD; kind_d = 1'b0; end
                    else if (char == CH_STAR) begin state_d = S_SP_FIELD; kind_d = 1'b1; end
                end
                S_SP_FIELD: begin
                    if (char == CH_SPACE) state_d = S_SP_FIELD;
                    else if (!kind && is_dec) begin
                        state_d = S_GRF; cnt_d = 8'd1; shift_grf = 1'b1;
                    end else if (kind && is_hex) begin
                        state_d = S_ADDR; cnt_d = 8'd1; shift_addr = 1'b1;
                    end
                end
                S_GRF: begin
                    if (is_dec && (cnt < 8'(GRF_DIGITS))) begin
                        state_d = S_GRF; cnt_d = cnt + 8'd1; shift_grf = 1'b1;
                    end else if (char == CH_SPACE) state_d = S_SP_LT;
                    else if (char == CH_LT) state_d = S_EQ;
                end
                S_ADDR: begin
                    if (is_hex && (cnt < 8'd8)) begin
                        state_d = S_ADDR; cnt_d = cnt + 8'd1; shift_addr = 1'b1;
                    end else if ((cnt == 8'd8) && (char == CH_SPACE)) state_d = S_SP_LT;
                    else if ((cnt == 8'd8) && (char == CH_LT)) state_d = S_EQ;
                end
                S_SP_LT: begin
                    if (char == CH_SPACE) state_d = S_SP_LT;
                    else if (char == CH_LT) state_d = S_EQ;
                end
                S_EQ:
                    if (char == CH_EQ) state_d = S_SP_DATA;
                S_SP_DATA: begin
                    if (char == CH_SPACE) state_d = S_SP_DATA;
                    else if (is_hex) begin state_d = S_DATA; cnt_d = 8'd1; end
                end
                S_DATA: begin
                    if (is_hex) begin
                        state_d = (cnt == 8'd7) ? S_HASH : S_DATA;
                        cnt_d   = (cnt == 8'd7) ? 8'd0 : cnt + 8'd1;
                    end
                end
                S_HASH:
                    if (char == CH_HASH) begin state_d = S_ACCEPT; accept_d = 1'b1; end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef TRACE_CHECKER_ERR_EN
    localparam int TIME_W = $clog2(10 ** TIME_DIGITS);
    localparam int GRF_W  = $clog2(10 ** GRF_DIGITS);

    logic [TIME_W-1:0] time_acc;
    logic [GRF_W-1:0]  grf_acc;
    logic [31:0]       pc_acc, addr_acc;
    logic [FREQ_W-1:0] half_freq;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            time_acc <= '0;
            grf_acc  <= '0;
            pc_acc   <= '0;
            addr_acc <= '0;
        end else begin
            if (shift_time) time_acc <= time_acc * TIME_W'(10) + TIME_W'(dec_val);
            if (shift_grf)  grf_acc  <= grf_acc * GRF_W'(10) + GRF_W'(dec_val);
            if (shift_pc)   pc_acc   <= {pc_acc[27:0], nibble};
            if (shift_addr) addr_acc <= {addr_acc[27:0], nibble};
        end
    end

    // A zero half-period cannot occur for legal freq; guarding it keeps the modulo defined
    always_comb begin
        half_freq       = freq >> 1;
        err_d           = '0;
        err_d[ERR_TIME] = (half_freq != '0) && ((32'(time_acc) % 32'(half_freq)) != 32'd0);
        err_d[ERR_PC]   = (pc_acc < PC_LO) || (pc_acc > PC_HI) || (pc_acc[1:0] != 2'b00);
        err_d[ERR_ADDR] = kind && ((addr_acc > ADDR_HI) || (addr_acc[1:0] != 2'b00));
        err_d[ERR_GRF]  = !kind && (32'(grf_acc) > 32'd31);
    end
`else
    logic unused_err_inputs;
    assign unused_err_inputs = ^{freq, nibble, dec_val, clr,
                                 shift_time, shift_pc, shift_grf, shift_addr};
    assign err_d = '0;
`endif

    // Stage boundary: parse state and the one-cycle ACCEPT result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            kind           <= 1'b0;
            format_type_p1 <= FT_NONE;
            error_code_p1  <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            kind           <= kind_d;
            format_type_p1 <= accept_d ? (kind ? FT_MEM : FT_REG) : FT_NONE;
            error_code_p1  <= accept_d ? err_d : 4'b0000;
        end
    end

    assign format_type = format_type_p1;
    assign error_code  = error_code_p1;

endmodule

// File: tb/tb_trace_line_checker.sv
// Directed, table-driven bench for trace_line_checker; error expectations
// collapse to zero when TRACE_CHECKER_ERR_EN is not defined.
module tb_trace_line_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char;
    logic [15:0] freq;
    logic [1:0]  format_type;
    logic [3:0]  error_code;

    int pass_cnt  = 0;
    int total_cnt = 0;

    trace_line_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .freq        (freq),
        .format_type (format_type),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      line;
        int         f;
        logic [1:0] ft;
        logic [3:0] ec;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] exp_ec(input logic [3:0] e);
`ifdef TRACE_CHECKER_ERR_EN
        return e;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic add(input string l, input int f, input logic [1:0] ft, input logic [3:0] ec);
        vec_t v;
        v.line = l; v.f = f; v.ft = ft; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input logic [7:0] c);
        @(negedge clk);
        char = c;
        @(posedge clk);
        #1;
    endtask

    // Drives a string; outputs must stay zero for every character but the last
    task automatic send_line(input string s, output bit quiet);
        logic [7:0] c;
        quiet = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            step(c);
            if (i < s.len() - 1 && (format_type !== 2'd0 || error_code !== 4'd0)) quiet = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;

        add("^10@00003010: $ 4 <= 0000000a#",          4,    2'd1, 4'b0000);
        add("^7@00003000: * 00002ffc <= 12345678#",    4,    2'd2, 4'b0001);
        add("^0@00005002:$32<=00000000#",              2,    2'd1, 4'b1010);
        add("^12345@00003000:$1<=00000000#",           2,    2'd0, 4'b0000);
        add("^1@0000^2@00003000:*00000000<=00000000#", 2,    2'd2, 4'b0000);
        add("^4@00004ffc:*00003000<=00000000#",        4,    2'd2, 4'b0100);
        add("^6@00003004:*00000001<=ffffffff#",        6,    2'd2, 4'b0100);
        add("^8@00003000:$31<=deadbeef#",              8,    2'd1, 4'b0000);
        add("^2@00002ffc:$0<=00000000#",               2,    2'd1, 4'b0010);
        add("^2@00005000:$0<=00000000#",               2,    2'd1, 4'b0010);
        add("^5@00003001:*00003002<=00000000#",        4,    2'd2, 4'b0111);
        add("^9999@00003000:$0031<=00000000#",         4,    2'd1, 4'b0001);
        add("^3000@00003000:$1<=00000000#",            4000, 2'd1, 4'b0001);
        add("^3000@00003000:$1<=00000000#",            2000, 2'd1, 4'b0000);
        add("^1@00003000:$00001<=00000000#",           2,    2'd0, 4'b0000);
        add("^1@0000300A:$1<=00000000#",               2,    2'd0, 4'b0000);
        add("^1@0000300:$1<=00000000#",                2,    2'd0, 4'b0000);
        add("^@00003000:$1<=00000000#",                2,    2'd0, 4'b0000);
        add("^1@00003000:$1<=0000000#",                2,    2'd0, 4'b0000);
        add("^1@00003000:$1< =00000000#",              2,    2'd0, 4'b0000);
        add("^1@00003000:*0000000<=00000000#",         2,    2'd0, 4'b0000);

        reset = 1'b1;
        char  = 8'h20;
        freq  = 16'd2;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ft", 32'(format_type), 32'd0);
        check("reset_ec", 32'(error_code), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            freq = 16'(vecs[k].f);
            send_line(vecs[k].line, quiet);
            check($sformatf("v%0d_quiet", k), 32'(quiet), 32'd1);
            check($sformatf("v%0d_ft", k), 32'(format_type), 32'(vecs[k].ft));
            check($sformatf("v%0d_ec", k), 32'(error_code), 32'(exp_ec(vecs[k].ec)));
            step(8'h20);
            check($sformatf("v%0d_drop", k), 32'({format_type, error_code}), 32'd0);
        end

        // Reset in the middle of a line discards it
        freq = 16'd2;
        send_line("^5@0000", quiet);
        @(negedge clk);
        reset = 1'b1;
        char  = 8'h30;
        @(posedge clk);
        #1;
        check("rst_mid_out", 32'({format_type, error_code}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send_line("3000:$1<=00000000#", quiet);
        check("rst_tail_quiet", 32'(quiet), 32'd1);
        check("rst_tail_ft", 32'(format_type), 32'd0);
        freq = 16'd4;
        send_line("^10@00003010: $ 4 <= 0000000a#", quiet);
        check("rst_recover_ft", 32'(format_type), 32'd1);

        // '^' arriving while ACCEPT is showing: result stays visible, parse restarts
        freq = 16'd4;
        send_line("^2@00003000:$5<=00000000#", quiet);
        check("b2b_first_ft", 32'(format_type), 32'd1);
        @(negedge clk);
        char = 8'h5e;
        #1;
        check("b2b_hold_ft", 32'(format_type), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_clear_ft", 32'(format_type), 32'd0);
        send_line("4@00003000:*00000008<=00000000#", quiet);
        check("b2b_second_quiet", 32'(quiet), 32'd1);
        check("b2b_second_ft", 32'(format_type), 32'd2);
        check("b2b_second_ec", 32'(error_code), 32'(exp_ec(4'b0000)));
        step(8'h20);
        check("b2b_second_drop", 32'(format_type), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
